// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM encoding,
// and the vector returned on an acknowledge that finds no eligible source.
package irq_ctrl_pkg;

  localparam logic [2:0] REG_PEND  = 3'd0;
  localparam logic [2:0] REG_MASK  = 3'd1;
  localparam logic [2:0] REG_ISR   = 3'd2;
  localparam logic [2:0] REG_EOI   = 3'd3;
  localparam logic [2:0] REG_VBASE = 3'd4;
  localparam logic [2:0] REG_STAT  = 3'd5;
  localparam logic [2:0] REG_EDGE  = 3'd6;
  localparam logic [2:0] REG_ECLR  = 3'd7;

  localparam logic [7:0] RD_UNUSED = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACKD = 2'd2
  } irq_state_t;

  // A spurious acknowledge reports the slot just past the last real source.
  function automatic logic [7:0] spurious_vec(input logic [7:0] base, input int unsigned nsrc);
    return base + 8'(nsrc);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; purely combinational.
module irq_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] i_vec,
  output logic               o_vld,
  output logic [2:0]         o_idx
);

  always_comb begin
    o_vld = 1'b0;
    o_idx = 3'd0;
    // Scan downward so the lowest set bit is the last to be written.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_vld = 1'b1;
        o_idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller with nesting, EOI and a req/ack CPU handshake.
// Optional rising-edge capture per source when IRQ_CTRL_EDGE_EN is defined.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         addr,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic [7:0]         rd_data,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               cpu_irq,
  input  logic               cpu_ack,
  output logic [7:0]         vector
);

  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_isr;
  logic [7:0]         r_vec_base;
  logic [7:0]         r_vector;
  irq_state_t         r_state;

  irq_state_t         w_state_nxt;
  logic [NUM_SRC-1:0] w_cand;
  logic               w_cand_vld;
  logic [2:0]         w_cand_idx;
  logic               w_isr_vld;
  logic [2:0]         w_isr_idx;
  logic               w_elig;
  logic               w_ack_hit;
  logic               w_ack_spur;
  logic               w_eoi;
  logic [NUM_SRC-1:0] w_isr_nxt;
  logic [NUM_SRC-1:0] w_ack_onehot;

  assign w_cand = r_pending & r_mask & ~r_isr;

  irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_cand_enc (
    .i_vec (w_cand),
    .o_vld (w_cand_vld),
    .o_idx (w_cand_idx)
  );

  irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_isr_enc (
    .i_vec (r_isr),
    .o_vld (w_isr_vld),
    .o_idx (w_isr_idx)
  );

  // Nesting: only a strictly higher-priority source may preempt the one in service.
  assign w_elig = w_cand_vld && (!w_isr_vld || (w_cand_idx < w_isr_idx));
  assign w_eoi  = wr_en && (addr == REG_EOI);
  assign w_ack_onehot = w_ack_hit ? (NUM_SRC'(1) << w_cand_idx) : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_ack_hit   = 1'b0;
    w_ack_spur  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_elig) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (cpu_ack) begin
          w_state_nxt = ST_ACKD;
          w_ack_hit   = w_elig;
          w_ack_spur  = !w_elig;
        end else if (!w_elig) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACKD: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // EOI retires the old lowest in-service bit before the newly acked bit is set.
  always_comb begin
    w_isr_nxt = r_isr;
    if (w_eoi && w_isr_vld) w_isr_nxt = w_isr_nxt & ~(NUM_SRC'(1) << w_isr_idx);
    w_isr_nxt = w_isr_nxt | w_ack_onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mask     <= '0;
      r_isr      <= '0;
      r_vec_base <= 8'h00;
      r_vector   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_isr   <= w_isr_nxt;
      if (wr_en && (addr == REG_MASK))  r_mask     <= wr_data[NUM_SRC-1:0];
      if (wr_en && (addr == REG_VBASE)) r_vec_base <= wr_data;
      if (w_ack_hit)       r_vector <= r_vec_base + 8'(w_cand_idx);
      else if (w_ack_spur) r_vector <= spurious_vec(r_vec_base, NUM_SRC);
    end
  end

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] r_edge_sel;
  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_edge_clr;
  logic [NUM_SRC-1:0] w_edge_pend;

  assign w_rise      = irq_src & ~r_prev;
  assign w_edge_clr  = w_ack_onehot |
                       ((wr_en && (addr == REG_ECLR)) ? wr_data[NUM_SRC-1:0] : '0);
  // Set is applied after clear so a coincident rising edge is not lost.
  assign w_edge_pend = (r_pending & ~w_edge_clr) | w_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_sel <= '0;
      r_prev     <= '0;
      r_pending  <= '0;
    end else begin
      r_prev    <= irq_src;
      r_pending <= (r_edge_sel & w_edge_pend) | (~r_edge_sel & irq_src);
      if (wr_en && (addr == REG_EDGE)) r_edge_sel <= wr_data[NUM_SRC-1:0];
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= irq_src;
  end
`endif

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      REG_PEND:  rd_data = 8'(r_pending);
      REG_MASK:  rd_data = 8'(r_mask);
      REG_ISR:   rd_data = 8'(r_isr);
      REG_EOI:   rd_data = 8'h00;
      REG_VBASE: rd_data = r_vec_base;
      REG_STAT:  rd_data = {7'h00, cpu_irq};
`ifdef IRQ_CTRL_EDGE_EN
      REG_EDGE:  rd_data = 8'(r_edge_sel);
      REG_ECLR:  rd_data = 8'h00;
`else
      REG_EDGE:  rd_data = RD_UNUSED;
      REG_ECLR:  rd_data = RD_UNUSED;
`endif
      default:   rd_data = 8'h00;
    endcase
  end

  assign cpu_irq = (r_state == ST_REQ);
  assign vector  = r_vector;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expected vectors are queued at acknowledge time and
// popped when the vector becomes valid; register state is checked by readback.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [7:0] irq_src;
  logic       cpu_irq;
  logic       cpu_ack;
  logic [7:0] vector;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  irq_ctrl #(.NUM_SRC(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq_src (irq_src),
    .cpu_irq (cpu_irq),
    .cpu_ack (cpu_ack),
    .vector  (vector)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (!cpu_irq && n < 20) begin
      tick();
      n++;
    end
    check(tag, {7'h0, cpu_irq}, 8'h01);
  endtask

  // Pulse cpu_ack for one cycle; the expected vector is queued before the edge.
  task automatic ack_and_check(input string tag, input logic [7:0] exp_vec);
    exp_q.push_back(exp_vec);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    check({tag, "_irq_low"}, {7'h0, cpu_irq}, 8'h00);
    if (exp_q.size() == 0) check({tag, "_queue"}, 8'h00, 8'h01);
    else                   check({tag, "_vec"}, vector, exp_q.pop_front());
  endtask

  initial begin
    rst_n = 1'b0; addr = 3'd0; wr_en = 1'b0; wr_data = 8'h00;
    irq_src = 8'h00; cpu_ack = 1'b0;
    #22;
    check("reset_irq", {7'h0, cpu_irq}, 8'h00);
    check("reset_vec", vector, 8'h00);
    rst_n = 1'b1;
    tick();
    rd_check("reset_mask", 3'd1, 8'h00);
    rd_check("reset_isr",  3'd2, 8'h00);
    rd_check("reset_vbase", 3'd4, 8'h00);
`ifndef IRQ_CTRL_EDGE_EN
    rd_check("rd_reg6", 3'd6, 8'hFF);
    rd_check("rd_reg7", 3'd7, 8'hFF);
`endif

    // Basic latency: source 2
    wr(3'd1, 8'hFF);
    wr(3'd4, 8'h40);
    irq_src = 8'h04;
    tick();
    check("lat_n1", {7'h0, cpu_irq}, 8'h00);
    rd_check("lat_pend", 3'd0, 8'h04);
    tick();
    check("lat_n2", {7'h0, cpu_irq}, 8'h01);
    rd_check("stat_reg", 3'd5, 8'h01);
    ack_and_check("src2", 8'h42);
    rd_check("src2_isr", 3'd2, 8'h04);
    irq_src = 8'h00;
    wr(3'd3, 8'h00);
    rd_check("src2_eoi", 3'd2, 8'h00);

    // Sources 5 and 1 together
    irq_src = 8'h22;
    wait_irq("two_req1");
    ack_and_check("two_a", 8'h41);
    rd_check("two_isr1", 3'd2, 8'h02);
    irq_src = 8'h20;
    tick(); tick();
    check("two_blocked", {7'h0, cpu_irq}, 8'h00);
    wr(3'd3, 8'h00);
    wait_irq("two_req2");
    ack_and_check("two_b", 8'h45);
    rd_check("two_isr2", 3'd2, 8'h20);
    irq_src = 8'h00;
    wr(3'd3, 8'h00);

    // Nesting
    irq_src = 8'h10;
    wait_irq("nest_req4");
    ack_and_check("nest4", 8'h44);
    irq_src = 8'h04;
    wait_irq("nest_req2");
    ack_and_check("nest2", 8'h42);
    rd_check("nest_isr", 3'd2, 8'h14);
    irq_src = 8'h00;
    wr(3'd3, 8'h00);
    rd_check("nest_eoi_low", 3'd2, 8'h10);
    irq_src = 8'h40;
    for (int i = 0; i < 5; i++) tick();
    check("nest_src6_blocked", {7'h0, cpu_irq}, 8'h00);
    wr(3'd3, 8'h00);
    wait_irq("nest_req6");
    ack_and_check("nest6", 8'h46);
    irq_src = 8'h00;
    wr(3'd3, 8'h00);

    // Spurious: mask cleared while REQ, ack lands when the mask change is visible
    irq_src = 8'h08;
    wait_irq("spur_req");
    wr(3'd1, 8'hF7);
    check("spur_still_req", {7'h0, cpu_irq}, 8'h01);
    ack_and_check("spur", 8'h48);
    rd_check("spur_isr", 3'd2, 8'h00);
    irq_src = 8'h00;
    tick(); tick();
    wr(3'd1, 8'hFF);

    // EOI with nothing in service, then EOI coincident with an ack
    wr(3'd3, 8'h00);
    rd_check("eoi_empty", 3'd2, 8'h00);
    irq_src = 8'h08;
    wait_irq("eoiack_req3");
    ack_and_check("eoiack3", 8'h43);
    irq_src = 8'h01;
    wait_irq("eoiack_req0");
    exp_q.push_back(8'h40);
    cpu_ack = 1'b1; addr = 3'd3; wr_en = 1'b1;
    tick();
    cpu_ack = 1'b0; wr_en = 1'b0;
    check("eoiack_vec", vector, exp_q.pop_front());
    rd_check("eoiack_isr", 3'd2, 8'h01);
    irq_src = 8'h00;
    wr(3'd3, 8'h00);

    // Level re-request: source held high through EOI requests again
    irq_src = 8'h80;
    wait_irq("lvl_req");
    ack_and_check("lvl7", 8'h47);
    wr(3'd3, 8'h00);
    wait_irq("lvl_rereq");
    ack_and_check("lvl7b", 8'h47);
    irq_src = 8'h00;
    wr(3'd3, 8'h00);

    // Reset mid-handshake
    irq_src = 8'h02;
    wait_irq("rst_req1");
    ack_and_check("rst1", 8'h41);
    irq_src = 8'h01;
    wait_irq("rst_req0");
    rst_n = 1'b0;
    #1;
    check("rst_irq_drop", {7'h0, cpu_irq}, 8'h00);
    rd_check("rst_isr", 3'd2, 8'h00);
    irq_src = 8'h00;
    rst_n = 1'b1;
    tick();

`ifdef IRQ_CTRL_EDGE_EN
    wr(3'd1, 8'hFF);
    wr(3'd4, 8'h40);
    wr(3'd6, 8'h01);
    rd_check("edge_sel", 3'd6, 8'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    wait_irq("edge_pulse_req");
    ack_and_check("edge0", 8'h40);
    rd_check("edge_pend_clr", 3'd0, 8'h00);
    wr(3'd3, 8'h00);
    irq_src = 8'h01;
    wait_irq("edge_hold_req");
    ack_and_check("edge0b", 8'h40);
    wr(3'd3, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    check("edge_no_rereq", {7'h0, cpu_irq}, 8'h00);
    rd_check("edge_pend_hold", 3'd0, 8'h00);
    irq_src = 8'h00;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
